// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: FSM state encoding
// and default timeout sizing.
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } ctrlState_e;

    localparam int DefTimeout = 255;
    localparam int DefToW     = 8;

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Clearable up-counter with a terminal-count flag, used to bound how long a
// memory access may stay outstanding.
module dmem_timeout_cnt
    import dmem_ctrl_pkg::*;
#(
    parameter int TO_W    = DefToW,
    parameter int TIMEOUT = DefTimeout
) (
    input  logic clk_i,
    input  logic start_i,
    input  logic clr,
    input  logic en,
    output logic termCnt
);

    localparam logic [TO_W-1:0] LastCount = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + TO_W'(1);
        end
    end

    // Only meaningful while counting; the owner leaves BUSY on this flag, so
    // the counter never wraps.
    assign termCnt = en && (count == LastCount);

endmodule

// File: rtl/dmem_access_ctrl.sv
// Sequences EX/MEM loads and stores onto a multi-cycle data memory, stalling
// the pipeline until the access completes or times out.
module dmem_access_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DefTimeout,
    parameter int TO_W    = DefToW
) (
    input  logic              clk_i,
    input  logic              start_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              mem_ready_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              stall_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rdata_valid_o,
    output logic              err_o,
    output logic [31:0]       stall_cnt_o
);

    ctrlState_e state;
    ctrlState_e nextState;
    logic       access;
    logic       timeoutTc;

    assign access = MemRead_i | MemWrite_i;

    dmem_timeout_cnt #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i   (clk_i),
        .start_i (start_i),
        .clr     (state == IDLE),
        .en      (state == BUSY),
        .termCnt (timeoutTc)
    );

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case statement leaves it unassigned (no latch inferred).
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (access) nextState = BUSY;
            BUSY:    if (mem_ready_i || timeoutTc) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        stall_o       = 1'b0;
        rdata_valid_o = 1'b0;
        case (state)
            IDLE:    stall_o = access;
            BUSY:    stall_o = 1'b1;
            DONE:    rdata_valid_o = 1'b1;
            default: ;
        endcase
    end

    // Request and latched access; a read+write collision is issued as a write.
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            rdata_o     <= '0;
            err_o       <= 1'b0;
        end else begin
            mem_req_o <= (nextState == BUSY);
            if (state == IDLE && access) begin
                mem_addr_o  <= addr_i;
                mem_wdata_o <= wdata_i;
                mem_we_o    <= MemWrite_i;
                if (MemRead_i && MemWrite_i) begin
                    err_o <= 1'b1;
                end
            end
            // Ready takes priority over a timeout landing in the same cycle.
            if (state == BUSY) begin
                if (mem_ready_i) begin
                    if (!mem_we_o) begin
                        rdata_o <= mem_rdata_i;
                    end
                end else if (timeoutTc) begin
                    err_o   <= 1'b1;
                    rdata_o <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            stall_cnt_o <= '0;
        end else if (stall_o && (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed vector table, reset and
// collision sequences, then randomized transactions against a transaction model.
module tb_dmem_access_ctrl;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;
    localparam int TO_W    = 8;

    logic              clk_i = 1'b0;
    logic              start_i;
    logic              MemRead_i;
    logic              MemWrite_i;
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] wdata_i;
    logic              mem_ready_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              stall_o;
    logic [DATA_W-1:0] rdata_o;
    logic              rdata_valid_o;
    logic              err_o;
    logic [31:0]       stall_cnt_o;

    dmem_access_ctrl #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) dut (
        .clk_i         (clk_i),
        .start_i       (start_i),
        .MemRead_i     (MemRead_i),
        .MemWrite_i    (MemWrite_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .mem_ready_i   (mem_ready_i),
        .mem_rdata_i   (mem_rdata_i),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .stall_o       (stall_o),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o),
        .err_o         (err_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Transaction-level model of the architecturally visible results.
    logic [31:0] expRdata = '0;
    logic        expErr   = 1'b0;
    logic [31:0] expCnt   = '0;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          latency;   // BUSY cycle carrying ready; 0 = never
        logic [31:0] memData;
        int          expStall;
        logic [31:0] expRdata;
        logic        expErr;
        logic [31:0] expCnt;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkCommon(input string tag, input logic eStall, input logic eReq, input logic eValid);
        check({tag, "_stall"}, 64'(stall_o), 64'(eStall));
        check({tag, "_req"}, 64'(mem_req_o), 64'(eReq));
        check({tag, "_valid"}, 64'(rdata_valid_o), 64'(eValid));
        check({tag, "_rdata"}, 64'(rdata_o), 64'(expRdata));
        check({tag, "_err"}, 64'(err_o), 64'(expErr));
        check({tag, "_stallcnt"}, 64'(stall_cnt_o), 64'(expCnt));
    endtask

    task automatic bumpCnt();
        if (expCnt != 32'hFFFF_FFFF) expCnt = expCnt + 32'd1;
    endtask

    task automatic idleCycle();
        @(negedge clk_i);
        MemRead_i   = 1'b0;
        MemWrite_i  = 1'b0;
        addr_i      = $urandom;
        wdata_i     = $urandom;
        mem_ready_i = 1'($urandom_range(0, 1));
        mem_rdata_i = $urandom;
        #1 checkCommon("idle", 1'b0, 1'b0, 1'b0);
    endtask

    // One full access: issue cycle, BUSY cycles, DONE cycle.
    task automatic runAccess(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input int latency,
                             input logic [31:0] memData, output int stallSeen,
                             output logic [31:0] rdataSeen, output logic errSeen);
        int n;
        n = (latency == 0 || latency > TIMEOUT) ? TIMEOUT : latency;
        stallSeen = 0;

        @(negedge clk_i);
        MemRead_i   = rd;
        MemWrite_i  = wr;
        addr_i      = addr;
        wdata_i     = wdata;
        mem_ready_i = 1'($urandom_range(0, 1));
        mem_rdata_i = $urandom;
        #1 checkCommon("issue", 1'b1, 1'b0, 1'b0);
        stallSeen += int'(stall_o);
        bumpCnt();
        if (rd && wr) expErr = 1'b1;

        for (int k = 1; k <= n; k++) begin
            @(negedge clk_i);
            addr_i      = $urandom;
            wdata_i     = $urandom;
            mem_ready_i = (k == latency);
            mem_rdata_i = (k == latency) ? memData : $urandom;
            #1 checkCommon("busy", 1'b1, 1'b1, 1'b0);
            check("busy_we", 64'(mem_we_o), 64'(wr));
            check("busy_addr", 64'(mem_addr_o), 64'(addr));
            check("busy_wdata", 64'(mem_wdata_o), 64'(wdata));
            stallSeen += int'(stall_o);
            bumpCnt();
            if (k == n) begin
                if (k == latency) begin
                    if (!wr) expRdata = memData;
                end else begin
                    expErr   = 1'b1;
                    expRdata = '0;
                end
            end
        end

        @(negedge clk_i);
        addr_i      = addr;
        wdata_i     = wdata;
        mem_ready_i = 1'($urandom_range(0, 1));
        mem_rdata_i = $urandom;
        #1 checkCommon("done", 1'b0, 1'b0, 1'b1);
        stallSeen += int'(stall_o);
        rdataSeen = rdata_o;
        errSeen   = err_o;
    endtask

    initial begin
        int          stallSeen;
        logic [31:0] rdataSeen;
        logic        errSeen;

        vecs[0] = '{"load_wait3",      1'b1, 1'b0, 32'h40, 32'h0,    3, 32'hDEADBEEF, 4, 32'hDEADBEEF, 1'b0, 32'd4};
        vecs[1] = '{"store_fast",      1'b0, 1'b1, 32'h80, 32'h1234, 1, 32'h0BADF00D, 2, 32'hDEADBEEF, 1'b0, 32'd6};
        vecs[2] = '{"ready_at_tc",     1'b1, 1'b0, 32'h44, 32'h0,    4, 32'hCAFEF00D, 5, 32'hCAFEF00D, 1'b0, 32'd11};
        vecs[3] = '{"load_timeout",    1'b1, 1'b0, 32'h48, 32'h0,    0, 32'h11111111, 5, 32'h0,        1'b1, 32'd16};
        vecs[4] = '{"after_timeout",   1'b1, 1'b0, 32'h4C, 32'h0,    2, 32'h55AA55AA, 3, 32'h55AA55AA, 1'b1, 32'd19};

        start_i     = 1'b0;
        MemRead_i   = 1'b0;
        MemWrite_i  = 1'b0;
        addr_i      = '0;
        wdata_i     = '0;
        mem_ready_i = 1'b0;
        mem_rdata_i = '0;
        repeat (2) @(negedge clk_i);
        #1 checkCommon("in_reset", 1'b0, 1'b0, 1'b0);
        check("in_reset_we", 64'(mem_we_o), 64'd0);
        check("in_reset_addr", 64'(mem_addr_o), 64'd0);
        check("in_reset_wdata", 64'(mem_wdata_o), 64'd0);
        start_i = 1'b1;

        repeat (10) idleCycle();

        for (int i = 0; i < 5; i++) begin
            runAccess(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].latency,
                      vecs[i].memData, stallSeen, rdataSeen, errSeen);
            check({vecs[i].name, "_stallcycles"}, 64'(stallSeen), 64'(vecs[i].expStall));
            check({vecs[i].name, "_rdata"}, 64'(rdataSeen), 64'(vecs[i].expRdata));
            check({vecs[i].name, "_err"}, 64'(errSeen), 64'(vecs[i].expErr));
            check({vecs[i].name, "_cnt"}, 64'(stall_cnt_o), 64'(vecs[i].expCnt));
            idleCycle();
        end

        // Reset asserted while an access is outstanding.
        @(negedge clk_i);
        MemRead_i   = 1'b1;
        MemWrite_i  = 1'b0;
        addr_i      = 32'h60;
        mem_ready_i = 1'b0;
        #1 checkCommon("rst_issue", 1'b1, 1'b0, 1'b0);
        bumpCnt();
        @(negedge clk_i);
        #1 check("rst_busy_req", 64'(mem_req_o), 64'd1);
        #1;
        start_i   = 1'b0;
        MemRead_i = 1'b0;
        #1;
        expRdata = '0;
        expErr   = 1'b0;
        expCnt   = '0;
        checkCommon("rst_async", 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        #1 checkCommon("rst_held", 1'b0, 1'b0, 1'b0);
        start_i = 1'b1;
        idleCycle();

        runAccess(1'b1, 1'b0, 32'h64, 32'h0, 1, 32'h13579BDF, stallSeen, rdataSeen, errSeen);
        check("post_rst_load_stall", 64'(stallSeen), 64'd2);
        check("post_rst_load_rdata", 64'(rdataSeen), 64'h13579BDF);
        check("post_rst_load_err", 64'(errSeen), 64'd0);
        idleCycle();

        // Read and write together: issued as a write and flagged.
        runAccess(1'b1, 1'b1, 32'h90, 32'h77, 2, 32'hFFFF0000, stallSeen, rdataSeen, errSeen);
        check("rdwr_stall", 64'(stallSeen), 64'd3);
        check("rdwr_rdata", 64'(rdataSeen), 64'h13579BDF);
        check("rdwr_err", 64'(errSeen), 64'd1);

        // Randomized transactions, including back-to-back issue.
        for (int t = 0; t < 300; t++) begin
            logic rd;
            logic wr;
            int   sel;
            int   gap;
            sel = $urandom_range(0, 19);
            rd  = (sel < 9) || (sel >= 18);
            wr  = !rd || (sel >= 18);
            runAccess(rd, wr, $urandom, $urandom, $urandom_range(0, TIMEOUT + 1), $urandom,
                      stallSeen, rdataSeen, errSeen);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) idleCycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
